// File: rtl/cubo_launch_scheduler.sv
// Launch scheduler for the falling cubes: waits LAUNCH_INTERVAL frames, picks a free slot
// round-robin, pulses its start line and drives LFSR-derived x/speed/colour buses.
module cubo_launch_scheduler #(
    parameter int          NUM_CUBES       = 4,
    parameter int          LAUNCH_INTERVAL = 60,
    parameter int          X_MAX           = 451,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic [NUM_CUBES-1:0] terminado,
    output logic [NUM_CUBES-1:0] start_cubo,
    output logic [8:0]           posicion_x_lanz,
    output logic [1:0]           velocidad_lanz,
    output logic [7:0]           color_lanz,
    output logic [NUM_CUBES-1:0] slots_ocupados,
    output logic [15:0]          cubos_lanzados
);

    localparam int PW = (NUM_CUBES > 1) ? $clog2(NUM_CUBES) : 1;
    localparam logic [7:0] LI8 = 8'(LAUNCH_INTERVAL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ESPERA = 2'd1;
    localparam logic [1:0] S_LANZA  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NUM_CUBES-1:0] start_q, start_d;
    logic [NUM_CUBES-1:0] slots_q, slots_d;
    logic [PW-1:0]        rr_q, rr_d;
    logic [PW-1:0]        sel_q, sel_d;
    logic [8:0]           x_q, x_d;
    logic [1:0]           vel_q, vel_d;
    logic [7:0]           col_q, col_d;
    logic [15:0]          lanzados_q, lanzados_d;

    logic                 frame;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    int                   cand;
    logic [8:0]           x_raw;
    logic [8:0]           x_map;
    logic [1:0]           vel_map;
    logic [7:0]           col_map;

    assign frame = (pixel_y == 10'd481) && (pixel_x == 10'd0);

    assign x_raw   = lfsr_q[8:0];
    assign x_map   = (x_raw > 9'(X_MAX)) ? x_raw - 9'(X_MAX + 1) : x_raw;
    assign vel_map = (lfsr_q[10:9] == 2'd0) ? 2'd1 : lfsr_q[10:9];
    assign col_map = (lfsr_q[15:8] == 8'd0) ? 8'hFF : lfsr_q[15:8];

    // First free slot at or after the round-robin pointer, with wrap-around.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_CUBES; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_CUBES) cand = cand - NUM_CUBES;
            if (!pick_found && !slots_q[PW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        start_d    = '0;
        slots_d    = slots_q & ~terminado;
        rr_d       = rr_q;
        sel_d      = sel_q;
        x_d        = x_q;
        vel_d      = vel_q;
        col_d      = col_q;
        lanzados_d = lanzados_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_ESPERA;
            end
            S_ESPERA: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LI8) begin
                    if (pick_found) begin
                        state_d           = S_LANZA;
                        start_d[pick_idx] = 1'b1;
                        sel_d             = pick_idx;
                        x_d               = x_map;
                        vel_d             = vel_map;
                        col_d             = col_map;
                    end
                end else if (frame) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LANZA: begin
                // The pulse already on start_q is committed regardless of enable.
                state_d    = S_ESPERA;
                cnt_d      = '0;
                slots_d    = slots_d | start_q;
                lanzados_d = lanzados_q + 16'd1;
                rr_d       = (sel_q == PW'(NUM_CUBES - 1)) ? '0 : sel_q + PW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            start_q    <= '0;
            slots_q    <= '0;
            rr_q       <= '0;
            sel_q      <= '0;
            x_q        <= '0;
            vel_q      <= '0;
            col_q      <= '0;
            lanzados_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            start_q    <= start_d;
            slots_q    <= slots_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            x_q        <= x_d;
            vel_q      <= vel_d;
            col_q      <= col_d;
            if (lanzados_d != lanzados_q) lanzados_q <= lanzados_d;
        end
    end

    assign start_cubo      = start_q;
    assign posicion_x_lanz = x_q;
    assign velocidad_lanz  = vel_q;
    assign color_lanz      = col_q;
    assign slots_ocupados  = slots_q;
    assign cubos_lanzados  = lanzados_q;

endmodule

// File: tb/tb_cubo_launch_scheduler.sv
// Directed bench for cubo_launch_scheduler: expected slots are queued before each launch
// and popped by a monitor that also checks the buses against a reference LFSR.
module tb_cubo_launch_scheduler;

    localparam int          N    = 4;
    localparam int          LI   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [9:0]    pixel_x = '0;
    logic [9:0]    pixel_y = '0;
    logic [N-1:0]  terminado = '0;
    logic [N-1:0]  start_cubo;
    logic [8:0]    posicion_x_lanz;
    logic [1:0]    velocidad_lanz;
    logic [7:0]    color_lanz;
    logic [N-1:0]  slots_ocupados;
    logic [15:0]   cubos_lanzados;

    int            n_assert = 0;
    int            n_fail = 0;
    int            sb_q[$];
    int            mon_slot;
    int            cyc = 0;
    int            lat;
    int            c0;
    logic [8:0]    last_x = '0;
    logic [15:0]   m_cur, m_prev;

    cubo_launch_scheduler #(
        .NUM_CUBES(N), .LAUNCH_INTERVAL(LI), .X_MAX(451), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .terminado(terminado),
        .start_cubo(start_cubo), .posicion_x_lanz(posicion_x_lanz),
        .velocidad_lanz(velocidad_lanz), .color_lanz(color_lanz),
        .slots_ocupados(slots_ocupados), .cubos_lanzados(cubos_lanzados)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [8:0] exp_x(input logic [15:0] v);
        logic [8:0] r;
        r = v[8:0];
        if (r >= 9'd452) r = r - 9'd452;
        return r;
    endfunction

    function automatic logic [1:0] exp_vel(input logic [15:0] v);
        return (v[10:9] == 2'd0) ? 2'd1 : v[10:9];
    endfunction

    function automatic logic [7:0] exp_col(input logic [15:0] v);
        return (v[15:8] == 8'd0) ? 8'hFF : v[15:8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR; m_prev is the value the DUT sampled at the decision edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cur  <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_cur;
            m_cur  <= lfsr_step(m_cur);
        end
    end

    always @(negedge clk) begin
        if (reset_n && start_cubo !== '0) begin
            check("start_expected", 32'(sb_q.size() != 0), 1);
            check("start_onehot", 32'($onehot(start_cubo)), 1);
            check("x_range", 32'(posicion_x_lanz <= 9'd451), 1);
            check("vel_nonzero", 32'(velocidad_lanz != 2'd0), 1);
            check("col_nonzero", 32'(color_lanz != 8'd0), 1);
            check("x_bus", 32'(posicion_x_lanz), 32'(exp_x(m_prev)));
            check("vel_bus", 32'(velocidad_lanz), 32'(exp_vel(m_prev)));
            check("col_bus", 32'(color_lanz), 32'(exp_col(m_prev)));
            last_x = exp_x(m_prev);
            if (sb_q.size() != 0) begin
                mon_slot = sb_q.pop_front();
                check("start_slot", 32'(start_cubo), 32'(1) << mon_slot);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        pixel_y = 10'd481;
        @(negedge clk);
        pixel_y = 10'd100;
    endtask

    task automatic frame();
        tick();
        idle(4);
    endtask

    task automatic pulse_term(input logic [N-1:0] m);
        @(negedge clk);
        terminado = m;
        @(negedge clk);
        terminado = '0;
    endtask

    task automatic wait_launch(input string tag);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 32'(sb_q.size()), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_start", 32'(start_cubo), 0);
        check("rst_slots", 32'(slots_ocupados), 0);
        check("rst_count", 32'(cubos_lanzados), 0);
        check("rst_x", 32'(posicion_x_lanz), 0);
        check("rst_vel", 32'(velocidad_lanz), 0);
        check("rst_col", 32'(color_lanz), 0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        idle(2);

        // Round-robin launches every second frame onto slots 0..3.
        for (int s = 0; s < N; s++) begin
            frame();
            sb_q.push_back(s);
            frame();
            wait_launch($sformatf("t2_launch%0d", s));
        end
        repeat (4) frame();
        check("t2_count", 32'(cubos_lanzados), 4);
        check("t2_slots_full", 32'(slots_ocupados), 32'hF);
        check("t2_bus_hold", 32'(posicion_x_lanz), 32'(last_x));

        // Freeing one slot while saturated relaunches exactly that slot.
        sb_q.push_back(2);
        @(negedge clk);
        terminado = 4'b0100;
        c0 = cyc;
        @(negedge clk);
        terminado = '0;
        wait_launch("t3_launch");
        lat = cyc - c0;
        check("t3_latency_ge2", 32'(lat >= 2), 1);
        idle(2);
        check("t3_count", 32'(cubos_lanzados), 5);
        check("t3_slots", 32'(slots_ocupados), 32'hF);

        // Disable mid-count, free slots, then a full interval is required again.
        frame();
        enable = 1'b0;
        idle(2);
        pulse_term(4'b1011);
        idle(1);
        pulse_term(4'b0001);
        idle(2);
        check("t5_slots_after_free", 32'(slots_ocupados), 32'h4);
        check("t5_count_held", 32'(cubos_lanzados), 5);
        enable = 1'b1;
        idle(2);
        frame();
        sb_q.push_back(3);
        frame();
        wait_launch("t5_launch_slot3");
        frame();
        sb_q.push_back(0);
        frame();
        wait_launch("t5_launch_slot0");
        check("t5_count", 32'(cubos_lanzados), 7);
        check("t5_slots", 32'(slots_ocupados), 32'hD);

        // Asynchronous reset while the start pulse is on the bus.
        frame();
        sb_q.push_back(1);
        tick();
        wait_launch("t1_launch");
        reset_n = 1'b0;
        #1;
        check("t1_start_cleared", 32'(start_cubo), 0);
        check("t1_slots_cleared", 32'(slots_ocupados), 0);
        check("t1_count_cleared", 32'(cubos_lanzados), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Continuous frame ticks, each launched slot finished right away.
        @(negedge clk);
        pixel_y = 10'd481;
        for (int i = 0; i < 1000; i++) begin
            sb_q.push_back(i % N);
            wait_launch("t4_launch");
            @(negedge clk);
            terminado = N'(1 << (i % N));
            @(negedge clk);
            terminado = '0;
        end
        pixel_y = 10'd100;
        idle(3);
        check("t4_count", 32'(cubos_lanzados), 1000);
        check("t4_slots_free", 32'(slots_ocupados), 0);

        // Launch counter wrap.
        force dut.lanzados_q = 16'hFFFE;
        @(negedge clk);
        release dut.lanzados_q;
        @(negedge clk);
        check("t6_preset", 32'(cubos_lanzados), 32'hFFFE);
        sb_q.push_back(0);
        frame();
        wait_launch("t6_launch_a");
        check("t6_count_ffff", 32'(cubos_lanzados), 32'hFFFF);
        frame();
        sb_q.push_back(1);
        frame();
        wait_launch("t6_launch_b");
        idle(2);
        check("t6_count_wrap", 32'(cubos_lanzados), 0);
        check("t6_slots", 32'(slots_ocupados), 32'h3);

        idle(5);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
